// File: rtl/led_pwm_breather.sv
// Purpose: 8-bit PWM LED driver whose level is either a manual input or a tick-driven breathing ramp.
// Latency: led and period_start are registered, 1 clk behind pwm_cnt. duty_active reloads only at the 255->0 wrap.
// Backpressure: none. tick is a fire-and-forget pulse, and every high cycle counts as one tick.
module led_pwm_breather #(
   parameter logic [7:0] STEP       = 8'd4,
   parameter logic [7:0] HOLD_TICKS = 8'd16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       enable,
   input  logic       mode,
   input  logic [7:0] duty_in,
   output logic       led,
   output logic [7:0] duty_active,
   output logic       period_start
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      HOLD_HI   = 3'd2,
      RAMP_DOWN = 3'd3,
      HOLD_LO   = 3'd4
   } state_t;

   // Breathing context: everything that must freeze together when mode=0.
   typedef struct packed {
      state_t     state;
      logic [7:0] level;
      logic [7:0] hold_cnt;
   } breath_t;

   // Upward step that would land at or above this value saturates to full-on.
   localparam logic [8:0] UP_LIMIT   = 9'd255 - {1'b0, STEP};
   // A level at or below 2*STEP would land at or under STEP, so it snaps to zero instead.
   localparam logic [8:0] DOWN_LIMIT = {1'b0, STEP} + {1'b0, STEP};
   localparam logic [7:0] HOLD_LAST  = HOLD_TICKS - 8'd1;

   logic [7:0] pwm_cnt;
   breath_t    br_q;
   breath_t    br_d;
   logic       adv;
   logic [8:0] up_sum;

   // The FSM only moves on a tick while the block is active and in breathe mode.
   assign adv    = tick & enable & mode;
   // The sum is 9 bits wide so the saturation test sees the true value, not an 8-bit wrap.
   assign up_sum = {1'b0, br_q.level} + {1'b0, STEP};

   // Breathing state register. rst wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         br_q.state    <= IDLE;
         br_q.level    <= 8'd0;
         br_q.hold_cnt <= 8'd0;
      end else begin
         br_q <= br_d;
      end
   end

   // Next breathing context. enable=0 parks the FSM at IDLE with level 0; mode=0 just holds.
   always_comb begin
      br_d = br_q;
      if (!enable) begin
         br_d.state    = IDLE;
         br_d.level    = 8'd0;
         br_d.hold_cnt = 8'd0;
      end else if (adv) begin
         case (br_q.state)
            IDLE: begin
               br_d.state    = RAMP_UP;
               br_d.level    = 8'd0;
               br_d.hold_cnt = 8'd0;
            end
            RAMP_UP: begin
               if (up_sum >= UP_LIMIT) begin
                  br_d.state    = HOLD_HI;
                  br_d.level    = 8'd255;
                  br_d.hold_cnt = 8'd0;
               end else begin
                  br_d.level = up_sum[7:0];
               end
            end
            HOLD_HI: begin
               if (br_q.hold_cnt == HOLD_LAST) begin
                  br_d.state    = RAMP_DOWN;
                  br_d.hold_cnt = 8'd0;
               end else begin
                  br_d.hold_cnt = br_q.hold_cnt + 8'd1;
               end
            end
            RAMP_DOWN: begin
               if ({1'b0, br_q.level} <= DOWN_LIMIT) begin
                  br_d.state    = HOLD_LO;
                  br_d.level    = 8'd0;
                  br_d.hold_cnt = 8'd0;
               end else begin
                  br_d.level = br_q.level - STEP;
               end
            end
            HOLD_LO: begin
               if (br_q.hold_cnt == HOLD_LAST) begin
                  br_d.state    = RAMP_UP;
                  br_d.hold_cnt = 8'd0;
               end else begin
                  br_d.hold_cnt = br_q.hold_cnt + 8'd1;
               end
            end
            default: begin
               br_d.state    = IDLE;
               br_d.level    = 8'd0;
               br_d.hold_cnt = 8'd0;
            end
         endcase
      end
   end

   // PWM timebase. Duty is latched only at the wrap, so a period is never glitched mid-way.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt      <= 8'd0;
         duty_active  <= 8'd0;
         led          <= 1'b0;
         period_start <= 1'b0;
      end else begin
         pwm_cnt      <= pwm_cnt + 8'd1;
         period_start <= (pwm_cnt == 8'd0);
         led          <= enable & (pwm_cnt < duty_active);
         if (pwm_cnt == 8'hFF) begin
            duty_active <= mode ? br_q.level : duty_in;
         end
      end
   end

endmodule

// File: tb/tb_led_pwm_breather.sv
// Purpose: self-checking bench for led_pwm_breather, using a per-cycle reference model plus hand-computed literals.
// Latency: the model steps 1 ns after each rising edge, using the inputs that edge sampled.
// Backpressure: none. Every wait on the DUT is bounded.
module tb_led_pwm_breather;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       enable;
   logic       mode;
   logic [7:0] duty_in;
   logic       led;
   logic [7:0] duty_active;
   logic       period_start;

   int vectors     = 0;
   int miscompares = 0;

   led_pwm_breather dut (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .enable       (enable),
      .mode         (mode),
      .duty_in      (duty_in),
      .led          (led),
      .duty_active  (duty_active),
      .period_start (period_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One breathing cycle with STEP=4, HOLD_TICKS=16 is 158 ticks long.
   // p counts ticks since RAMP_UP was entered at level 0:
   //   p 0..62   : rising, 4*p
   //   p 63..79  : 255 (saturated, then 16 hold ticks)
   //   p 80..141 : falling, 255 - 4*(p-79)
   //   p 142..157: 0 (snapped, then 16 hold ticks)
   function automatic int breath_level(input int p);
      if (p <= 62)       return 4 * p;
      else if (p <= 79)  return 255;
      else if (p <= 141) return 255 - 4 * (p - 79);
      else               return 0;
   endfunction

   int m_cnt;
   bit m_idle;
   int m_p;
   int m_duty;
   bit m_led;
   bit m_ps;
   int m_lvl;

   // Reference model and per-cycle comparison.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            m_cnt = 0; m_duty = 0; m_led = 0; m_ps = 0; m_idle = 1; m_p = 0;
         end else begin
            m_lvl = m_idle ? 0 : breath_level(m_p);
            m_led = enable && (m_cnt < m_duty);
            m_ps  = (m_cnt == 0);
            if (m_cnt == 255) m_duty = mode ? m_lvl : int'(duty_in);
            m_cnt = (m_cnt + 1) % 256;
            if (!enable) begin
               m_idle = 1; m_p = 0;
            end else if (tick && mode) begin
               if (m_idle) begin
                  m_idle = 0; m_p = 0;
               end else begin
                  m_p = (m_p + 1) % 158;
               end
            end
         end
         check("cyc_led", led, m_led);
         check("cyc_duty_active", duty_active, m_duty);
         check("cyc_period_start", period_start, m_ps);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ticks(input int n, input int gap);
      repeat (n) begin
         @(negedge clk) tick = 1'b1;
         @(negedge clk) tick = 1'b0;
         cyc(gap - 1);
      end
   endtask

   task automatic hold_tick_high(input int n);
      @(negedge clk) tick = 1'b1;
      cyc(n);
      tick = 1'b0;
   endtask

   // Returns at the first sample of a new period, so duty_active is the freshly loaded value.
   task automatic wait_wrap();
      int k;
      cyc(2);
      k = 0;
      while (period_start !== 1'b1 && k < 600) begin
         @(negedge clk);
         k++;
      end
      if (k >= 600) check("wrap_timeout", 0, 1);
   endtask

   // Counts led-high samples over one full period; optionally changes duty_in mid-period.
   task automatic measure(input int chg_idx, input logic [7:0] chg_val, output int hi);
      wait_wrap();
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         if (i == chg_idx) duty_in = chg_val;
         if (led === 1'b1) hi++;
         @(negedge clk);
      end
   endtask

   int hi;

   initial begin
      rst = 1'b1; tick = 1'b0; enable = 1'b1; mode = 1'b0; duty_in = 8'd200;

      // Reset held for 3 edges; outputs must be zero throughout.
      cyc(3);
      check("rst_led", led, 0);
      check("rst_duty", duty_active, 0);
      check("rst_ps", period_start, 0);
      rst = 1'b0;
      @(negedge clk);
      check("first_ps", period_start, 1);
      check("first_duty", duty_active, 0);

      // Manual mode duties.
      duty_in = 8'd64;
      measure(-1, 8'd0, hi);  check("man_64", hi, 64);
      duty_in = 8'd0;
      measure(-1, 8'd0, hi);  check("man_0", hi, 0);
      duty_in = 8'd255;
      measure(-1, 8'd0, hi);  check("man_255", hi, 255);

      // Mid-period change from 64 to 192 at pwm_cnt=100.
      duty_in = 8'd64;
      measure(-1, 8'd0, hi);    check("mid_pre", hi, 64);
      measure(100, 8'd192, hi); check("mid_cur", hi, 64);
      measure(-1, 8'd0, hi);    check("mid_next", hi, 192);

      // Breathing, with a tick every 10 clk.
      mode = 1'b1;
      pulse_ticks(63, 10); wait_wrap(); check("br_248", duty_active, 248);
      pulse_ticks(1, 10);  wait_wrap(); check("br_sat255", duty_active, 255);
      pulse_ticks(16, 10); wait_wrap(); check("br_hold_hi", duty_active, 255);
      pulse_ticks(1, 10);  wait_wrap(); check("br_251", duty_active, 251);
      pulse_ticks(61, 10); wait_wrap(); check("br_7", duty_active, 7);
      pulse_ticks(1, 10);  wait_wrap(); check("br_floor0", duty_active, 0);
      pulse_ticks(16, 10); wait_wrap(); check("br_hold_lo", duty_active, 0);
      pulse_ticks(1, 10);  wait_wrap(); check("br_4", duty_active, 4);
      pulse_ticks(200, 10);
      pulse_ticks(70, 10); wait_wrap(); check("br_down_119", duty_active, 119);

      // Enable drop during RAMP_DOWN.
      check("en_led_before", led, 1);
      enable = 1'b0;
      @(negedge clk);
      check("en_led_off", led, 0);
      wait_wrap(); check("en_level0", duty_active, 0);
      enable = 1'b1;
      pulse_ticks(2, 10); wait_wrap(); check("en_restart_4", duty_active, 4);

      // Reset mid-ramp.
      pulse_ticks(5, 3);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check("rst2_led", led, 0);
      check("rst2_duty", duty_active, 0);
      check("rst2_ps", period_start, 0);

      // Consecutive tick cycles each count: IDLE->0 plus 25 steps gives level 100.
      hold_tick_high(26); wait_wrap(); check("burst_100", duty_active, 100);

      // Mode freeze.
      mode = 1'b0; duty_in = 8'd37;
      pulse_ticks(20, 10); wait_wrap(); check("frz_manual", duty_active, 37);
      mode = 1'b1;
      wait_wrap(); check("frz_hold100", duty_active, 100);
      pulse_ticks(1, 10); wait_wrap(); check("frz_resume104", duty_active, 104);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
